// File: rtl/csa_pkg.sv
// Shared constants, state encoding and group-constant helper
// for the serial key schedule.
package csa_pkg;

  localparam int KEY_BYTES  = 56;
  localparam int KEY_ROUNDS = 7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXPAND,
    ST_STREAM
  } ks_state_e;

  // Group g is whitened with its own index replicated over 8 bytes.
  function automatic logic [63:0] grp_xor(input logic [2:0] g);
    grp_xor = {8{5'b00000, g}};
  endfunction

endpackage

// File: rtl/key_perm.sv
// Fixed 64-bit key bit permutation: out[i] = in[(13*i+7) mod 64].
// 13 is odd, so the mapping is a bijection on the bit positions.
module key_perm (
  input  logic [63:0] i_d,
  output logic [63:0] o_q
);

  for (genvar i = 0; i < 64; i++) begin : g_bit
    assign o_q[i] = i_d[(13 * i + 7) % 64];
  end

endmodule

// File: rtl/key_schedule_serial.sv
// Serial key schedule: 7-cycle iterative expansion into a 448-bit
// store, then a valid/ready byte stream in either direction.
module key_schedule_serial
  import csa_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [63:0] i_ck,
  input  logic        i_ck_valid,
  output logic        o_ck_ready,
  input  logic        i_dir,
  output logic [7:0]  o_kb,
  output logic        o_kb_valid,
  input  logic        i_kb_ready,
  output logic        o_kb_last,
  output logic        o_busy
);

  localparam logic [5:0] LAST_IDX  = 6'(KEY_BYTES - 1);
  localparam logic [2:0] FIRST_GRP = 3'(KEY_ROUNDS - 1);

  ks_state_e    state;
  ks_state_e    state_d;
  logic [63:0]  work;
  logic [63:0]  perm_q;
  logic [447:0] store;
  logic [2:0]   grp;
  logic [5:0]   cnt;
  logic [5:0]   cnt_nxt;
  logic [5:0]   idx;
  logic [7:0]   byte_sel;
  logic         dir_q;
  logic         ck_hs;
  logic         kb_hs;

  assign o_ck_ready = (state == ST_IDLE);
  assign o_busy     = (state != ST_IDLE);
  assign ck_hs      = i_ck_valid & o_ck_ready;
  assign kb_hs      = o_kb_valid & i_kb_ready;

  key_perm u_perm (
    .i_d (work),
    .o_q (perm_q)
  );

  // Before the first byte is loaded the counter points at byte 0;
  // afterwards the mux looks one byte ahead of the presented one.
  always_comb begin
    cnt_nxt  = o_kb_valid ? cnt + 6'd1 : cnt;
    idx      = dir_q ? LAST_IDX - cnt_nxt : cnt_nxt;
    byte_sel = store[{idx, 3'b000} +: 8];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      ST_IDLE: begin
        if (ck_hs) state_d = ST_EXPAND;
      end
      ST_EXPAND: begin
        if (grp == 3'd0) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (kb_hs && o_kb_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      work       <= '0;
      store      <= '0;
      grp        <= '0;
      cnt        <= '0;
      dir_q      <= 1'b0;
      o_kb       <= 8'h00;
      o_kb_valid <= 1'b0;
      o_kb_last  <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (ck_hs) begin
            work  <= i_ck;
            dir_q <= i_dir;
            grp   <= FIRST_GRP;
            cnt   <= '0;
          end
        end
        ST_EXPAND: begin
          work <= perm_q;
          store[{grp, 6'b000000} +: 64] <= perm_q ^ grp_xor(grp);
          if (grp != 3'd0) grp <= grp - 3'd1;
        end
        ST_STREAM: begin
          if (!o_kb_valid) begin
            o_kb       <= byte_sel;
            o_kb_valid <= 1'b1;
            o_kb_last  <= 1'b0;
          end else if (i_kb_ready) begin
            if (o_kb_last) begin
              o_kb_valid <= 1'b0;
              o_kb_last  <= 1'b0;
              cnt        <= '0;
            end else begin
              cnt       <= cnt_nxt;
              o_kb      <= byte_sel;
              o_kb_last <= (cnt_nxt == LAST_IDX);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/key_schedule_serial.md
KEY_SCHEDULE_SERIAL -- requirements
Module: key_schedule_serial

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset; ports i_clk and i_rst.
REQ-002 SHALL have ports: i_clk, input, 1, clock, rising edge.
REQ-003 SHALL have ports: i_rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have ports: i_ck, input, 64, control word, sampled on key handshake.
REQ-005 SHALL have ports: i_ck_valid, input, 1, control word offered.
REQ-006 SHALL have ports: o_ck_ready, output, 1, block accepts a control word.
REQ-007 SHALL have ports: i_dir, input, 1, stream order (0 = byte 0 up to 55, 1 = byte 55 down to 0), sampled on key handshake.
REQ-008 SHALL have ports: o_kb, output, 8, round-key byte.
REQ-009 SHALL have ports: o_kb_valid, output, 1, o_kb is valid.
REQ-010 SHALL have ports: i_kb_ready, input, 1, consumer takes o_kb.
REQ-011 SHALL have ports: o_kb_last, output, 1, marks the 56th streamed byte.
REQ-012 SHALL have ports: o_busy, output, 1, high in EXPAND or STREAM.

Function
REQ-013 SHALL implement three states: IDLE, EXPAND, STREAM.
REQ-014 SHALL drive o_ck_ready high only in IDLE; key handshake = i_ck_valid & o_ck_ready.
REQ-015 On key handshake SHALL latch i_ck into the working register and i_dir, then enter EXPAND.
REQ-016 EXPAND SHALL last exactly 7 cycles with one permutation per cycle, g counting 6 down to 0.
REQ-017 In EXPAND, each cycle SHALL apply the key permutation to the working register and store it as group g XOR byte value g replicated 8 times; group g = perm^(7-g)(i_ck) ^ {8{g}}.
REQ-018 Byte n (0..55) of the schedule SHALL be bits [8n+7:8n] of the 448-bit store; group g holds bytes 8g..8g+7.
REQ-019 After the 7th EXPAND cycle SHALL enter STREAM; first o_kb_valid asserted 8 cycles after the key-handshake edge.
REQ-020 STREAM SHALL present bytes in the order selected by latched dir, one per byte handshake (o_kb_valid & i_kb_ready).
REQ-021 With o_kb_valid high and i_kb_ready low, o_kb, o_kb_last and o_kb_valid SHALL hold stable.
REQ-022 Back-to-back handshakes SHALL sustain one byte per cycle.
REQ-023 o_kb_last SHALL be high exactly with the 56th byte (index 55 ascending, index 0 descending).
REQ-024 The handshake of the last byte SHALL return to IDLE; o_ck_ready high on the next cycle, o_kb_valid low.
REQ-025 i_ck_valid in EXPAND or STREAM SHALL be ignored; no key is lost silently because o_ck_ready is low.
REQ-026 The byte counter SHALL be 6 bits, range 0..55, and never wrap past the end.
REQ-027 Changes to i_dir or i_ck outside the key handshake SHALL have no effect.

Reset
REQ-028 Assertion of i_rst at any time, including mid-EXPAND or mid-STREAM, SHALL immediately force IDLE.
REQ-029 Reset values: o_ck_ready=1, o_kb=8'h00, o_kb_valid=0, o_kb_last=0, o_busy=0, key store and counters = 0.
REQ-030 After reset deassertion, the first key SHALL be accepted on the first cycle with i_ck_valid high.

Structure
REQ-031 Shared package csa_pkg SHALL hold KEY_BYTES=56, KEY_ROUNDS=7, the state enumeration and the per-group XOR constant function.
REQ-032 SHALL instantiate exactly one key_perm sub-module, reused every EXPAND cycle; no unrolled permutation chain.
REQ-033 The 448-bit schedule store SHALL be registers; the output byte mux is registered.

Verification
REQ-034 i_ck=64'h0, i_dir=0, i_kb_ready=1 -> bytes 00 x8, 01 x8, ... 06 x8; first valid 8 cycles after handshake; last byte 06 with o_kb_last.
REQ-035 i_ck=64'hFFFFFFFFFFFFFFFF, i_dir=1 -> bytes F9 x8, FA x8, ... FF x8 in descending index order; o_kb_last on final FF.
REQ-036 Random i_ck, random i_kb_ready stalls -> o_kb stable while stalled; stream equals the combinational 56-byte golden expansion; exactly 56 handshakes.
REQ-037 i_ck_valid held high throughout a run -> second key accepted only on the cycle after the last-byte handshake; o_ck_ready never high in EXPAND or STREAM.
REQ-038 i_rst pulsed at EXPAND cycle 3 and at STREAM byte 20 -> all outputs at reset values immediately; the next key yields a correct full stream.
